// File: rtl/keyboard_scanner_pkg.sv
// Shared encodings for the keyboard scanner: selection policies, the "no note"
// value and the note-player FSM states.
package keyboard_pkg;

  localparam int unsigned SEL_EXCLUSIVE = 0;
  localparam int unsigned SEL_LOWEST    = 1;
  localparam int unsigned SEL_LAST      = 2;

  localparam int unsigned NOTE_NONE     = 0;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PLAYING = 1'b1
  } state_t;

endpackage

// File: rtl/keyboard_scanner_key_debounce.sv
// One key: two-flop synchroniser followed by a stability counter that accepts
// a level change only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_key_db
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  // Any sample matching the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_db   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_key;
      r_sync <= r_meta;
      if (r_sync != r_db) begin
        if (r_cnt == CNT_LAST) begin
          r_db  <= r_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_key_db = r_db;

endmodule

// File: rtl/keyboard_scanner.sv
// Debounced N-key scanner: picks one note under the configured multi-key
// policy, honours sustain, and drives registered note/LED outputs and strobes.
module keyboard_scanner
  import keyboard_pkg::*;
#(
  parameter int unsigned N_KEYS          = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SEL_MODE        = SEL_EXCLUSIVE,
  parameter int unsigned NOTE_W          = $clog2(N_KEYS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  input  logic              sustain,
  output logic [NOTE_W-1:0] note_out,
  output logic [N_KEYS-1:0] led_out,
  output logic              note_on,
  output logic              note_off
);

  localparam logic [NOTE_W-1:0] NONE = NOTE_W'(NOTE_NONE);

  function automatic logic [NOTE_W-1:0] f_lowest(input logic [N_KEYS-1:0] v);
    f_lowest = NONE;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = NOTE_W'(i + 1);
    end
  endfunction

  function automatic logic [N_KEYS-1:0] f_onehot(input logic [NOTE_W-1:0] n);
    for (int i = 0; i < int'(N_KEYS); i++) begin
      f_onehot[i] = (n == NOTE_W'(i + 1));
    end
  endfunction

  logic [N_KEYS-1:0] w_key_db;
  logic [N_KEYS-1:0] w_rise;
  logic              w_last_held;
  logic [NOTE_W-1:0] w_sel_last;
  logic [NOTE_W-1:0] w_target;

  logic [N_KEYS-1:0] r_db_prev;
  logic [NOTE_W-1:0] r_last;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NOTE_W-1:0] w_note_nxt;
  logic              w_on_nxt;
  logic              w_off_nxt;

  logic [NOTE_W-1:0] r_note;
  logic [N_KEYS-1:0] r_led;
  logic              r_on;
  logic              r_off;

  for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_key   (key_in[g]),
      .o_key_db(w_key_db[g])
    );
  end

  // Target note selection from the debounced vector.
  always_comb begin
    w_rise      = w_key_db & ~r_db_prev;
    w_last_held = |(w_key_db & f_onehot(r_last));
    w_sel_last  = NONE;
    if (|w_rise) begin
      w_sel_last = f_lowest(w_rise);
    end else if (w_last_held) begin
      w_sel_last = r_last;
    end else begin
      w_sel_last = f_lowest(w_key_db);
    end

    w_target = NONE;
    case (SEL_MODE)
      SEL_LOWEST: w_target = f_lowest(w_key_db);
      SEL_LAST:   w_target = w_sel_last;
      default: begin
        if ((w_key_db != '0) && ((w_key_db & (w_key_db - N_KEYS'(1))) == '0)) begin
          w_target = f_lowest(w_key_db);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_prev <= '0;
      r_last    <= NONE;
    end else begin
      r_db_prev <= w_key_db;
      r_last    <= w_sel_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_target != NONE) w_state_nxt = ST_PLAYING;
      ST_PLAYING: if ((w_target == NONE) && !sustain) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // A held (sustained) note is only ever replaced by a different selection.
  always_comb begin
    w_note_nxt = r_note;
    w_on_nxt   = 1'b0;
    w_off_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_note_nxt = w_target;
        w_on_nxt   = (w_target != NONE);
      end
      ST_PLAYING: begin
        if (w_target != NONE) begin
          w_note_nxt = w_target;
          w_on_nxt   = (w_target != r_note);
        end else if (!sustain) begin
          w_note_nxt = NONE;
          w_off_nxt  = 1'b1;
        end
      end
      default: w_note_nxt = NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_note <= NONE;
      r_led  <= '0;
      r_on   <= 1'b0;
      r_off  <= 1'b0;
    end else begin
      r_note <= w_note_nxt;
      r_led  <= f_onehot(w_note_nxt);
      r_on   <= w_on_nxt;
      r_off  <= w_off_nxt;
    end
  end

  assign note_out = r_note;
  assign led_out  = r_led;
  assign note_on  = r_on;
  assign note_off = r_off;

endmodule
